// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank write-back arbiter.
// Defines the architectural register count, index/data widths and the
// requester encoding used for the round-robin winner state.
package regfile_wb_arbiter_pkg;

  localparam int NREG = 16;  // architectural registers / scoreboard width
  localparam int AW   = 4;   // register index width
  localparam int DW   = 32;  // data width

  // Write-back requester identity; also the round-robin state encoding.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus carrying the ALU and load (LDR) requesters.
// master = the execute/memory side presenting requests,
// slave  = the arbiter returning same-cycle grants.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic          alu_req;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;
  logic          alu_gnt;

  logic          mem_req;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          mem_gnt;

  modport master (
    output alu_req, alu_dest, alu_data,
    input  alu_gnt,
    output mem_req, mem_dest, mem_data,
    input  mem_gnt
  );

  modport slave (
    input  alu_req, alu_dest, alu_data,
    output alu_gnt,
    input  mem_req, mem_dest, mem_data,
    output mem_gnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A new issue sets a bit, an accepted write-back clears it; when both hit
// the same register in one cycle the set wins because the newly issued
// write supersedes the one that just retired. hazard looks only at the
// registered bits, so a same-cycle clear is not bypassed.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_valid,
  input  logic [AW-1:0]   set_dest,
  input  logic            clr_valid,
  input  logic [AW-1:0]   clr_dest,
  input  logic [AW-1:0]   chk_src1,
  input  logic [AW-1:0]   chk_src2,
  output logic [NREG-1:0] busy,
  output logic            hazard
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // Per-register decode of set/clear with set taking priority.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign set_vec[gi]   = set_valid && (set_dest == AW'(gi));
      assign clr_vec[gi]   = clr_valid && (clr_dest == AW'(gi));
      assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  // Busy register; cleared by reset so requesters start from a clean slate.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy   = busy_reg;
  assign hazard = busy_reg[chk_src1] | busy_reg[chk_src2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single write port of the 16x32 register bank.
// Round-robin between the ALU and load paths (1 bit of state), registers
// the winner onto the bank's dest/data inputs, and maintains the
// pending-write scoreboard used by the issue stage.
// Optional: define REGFILE_WB_STATS_EN to add a saturating 16-bit
// conflict_cnt output counting cycles with both requests high.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_dest,
  input  logic [AW-1:0]        chk_src1,
  input  logic [AW-1:0]        chk_src2,
  output logic                 hazard,
  output logic [NREG-1:0]      busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_dest,
  output logic [DW-1:0]        rf_data
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt
`endif
);

  wb_src_e       last_winner_reg;
  wb_src_e       last_winner_next;
  logic          alu_gnt;
  logic          mem_gnt;
  logic          grant_valid;
  logic [AW-1:0] grant_dest;
  logic [DW-1:0] grant_data;

  logic          rf_we_reg;
  logic [AW-1:0] rf_dest_reg;
  logic [DW-1:0] rf_data_reg;

  // Round-robin state register: remembers who was granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_reg <= WB_MEM;
    end else begin
      last_winner_reg <= last_winner_next;
    end
  end

  // Grant decision: a lone requester wins; on conflict the one that did not
  // win last time is granted, so a loser never waits more than one cycle.
  always_comb begin
    alu_gnt          = 1'b0;
    mem_gnt          = 1'b0;
    last_winner_next = last_winner_reg;
    if (wb.alu_req && (!wb.mem_req || last_winner_reg == WB_MEM)) begin
      alu_gnt          = 1'b1;
      last_winner_next = WB_ALU;
    end else if (wb.mem_req) begin
      mem_gnt          = 1'b1;
      last_winner_next = WB_MEM;
    end
  end

  assign wb.alu_gnt  = alu_gnt;
  assign wb.mem_gnt  = mem_gnt;
  assign grant_valid = alu_gnt | mem_gnt;
  assign grant_dest  = alu_gnt ? wb.alu_dest : wb.mem_dest;
  assign grant_data  = alu_gnt ? wb.alu_data : wb.mem_data;

  // Write-port register: one-cycle write pulse; dest/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg   <= 1'b0;
      rf_dest_reg <= '0;
      rf_data_reg <= '0;
    end else begin
      rf_we_reg <= grant_valid;
      if (grant_valid) begin
        rf_dest_reg <= grant_dest;
        rf_data_reg <= grant_data;
      end
    end
  end

  assign rf_we   = rf_we_reg;
  assign rf_dest = rf_dest_reg;
  assign rf_data = rf_data_reg;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_dest  (issue_dest),
    .clr_valid (grant_valid),
    .clr_dest  (grant_dest),
    .chk_src1  (chk_src1),
    .chk_src2  (chk_src2),
    .busy      (busy),
    .hazard    (hazard)
  );

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conflict_cnt_reg;

  // Saturating count of cycles in which both requesters compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if (wb.alu_req && wb.mem_req && conflict_cnt_reg != 16'hFFFF) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a directed vector table,
// hand-written reset/stat sequences and a randomized run checked against
// a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic [3:0]  chk_src1;
  logic [3:0]  chk_src2;
  logic        hazard;
  logic [15:0] busy;
  logic        rf_we;
  logic [3:0]  rf_dest;
  logic [31:0] rf_data;
`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .chk_src1    (chk_src1),
    .chk_src2    (chk_src2),
    .hazard      (hazard),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_dest     (rf_dest),
    .rf_data     (rf_data)
`ifdef REGFILE_WB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    wb.alu_req  = 1'b0; wb.alu_dest = '0; wb.alu_data = '0;
    wb.mem_req  = 1'b0; wb.mem_dest = '0; wb.mem_data = '0;
    issue_valid = 1'b0; issue_dest = '0;
    chk_src1    = '0;   chk_src2   = '0;
  endtask

  typedef struct {
    logic        ar; logic [3:0] ad; logic [31:0] adata;
    logic        mr; logic [3:0] md; logic [31:0] mdata;
    logic        iv; logic [3:0] id;
    logic [3:0]  s1; logic [3:0] s2;
    logic        e_agnt; logic e_mgnt; logic e_haz;
    logic        e_we; logic [3:0] e_dest; logic [31:0] e_data; logic [15:0] e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic ar, input logic [3:0] ad, input logic [31:0] adata,
    input logic mr, input logic [3:0] md, input logic [31:0] mdata,
    input logic iv, input logic [3:0] id, input logic [3:0] s1, input logic [3:0] s2,
    input logic e_agnt, input logic e_mgnt, input logic e_haz,
    input logic e_we, input logic [3:0] e_dest, input logic [31:0] e_data,
    input logic [15:0] e_busy);
    vec_t v;
    v.ar = ar; v.ad = ad; v.adata = adata;
    v.mr = mr; v.md = md; v.mdata = mdata;
    v.iv = iv; v.id = id; v.s1 = s1; v.s2 = s2;
    v.e_agnt = e_agnt; v.e_mgnt = e_mgnt; v.e_haz = e_haz;
    v.e_we = e_we; v.e_dest = e_dest; v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vecs[14];

  // Behavioural model state for the randomized run.
  bit          busy_m[16];
  wb_src_e     last_m;
  logic        we_m;
  logic [3:0]  dest_m;
  logic [31:0] data_m;

  function automatic logic [15:0] pack_busy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
    last_m = WB_MEM; we_m = 1'b0; dest_m = '0; data_m = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a_pend, m_pend;
    logic [3:0]  a_d, m_d;
    logic [31:0] a_data, m_data;
    logic        exp_a, exp_m, exp_h;
    logic        iv_r;
    logic [3:0]  id_r, s1_r, s2_r;

    rst = 1'b1;
    set_idle();
    // ---------------- reset state ----------------
    @(posedge clk); #1;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_dest", 32'(rf_dest), 32'd0);
    check("reset_rf_data", rf_data, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    vecs[0]  = mk(1,3,32'h12345678, 0,0,0,        0,0, 0,0, 1,0,0, 1,3,32'h12345678,16'h0000);
    vecs[1]  = mk(0,0,0,            0,0,0,        0,0, 0,0, 0,0,0, 0,3,32'h12345678,16'h0000);
    vecs[2]  = mk(0,0,0,            1,9,32'h99,   0,0, 0,0, 0,1,0, 1,9,32'h99,16'h0000);
    vecs[3]  = mk(1,1,32'h11,       1,2,32'h22,   0,0, 0,0, 1,0,0, 1,1,32'h11,16'h0000);
    vecs[4]  = mk(1,1,32'h11,       1,2,32'h22,   0,0, 0,0, 0,1,0, 1,2,32'h22,16'h0000);
    vecs[5]  = mk(1,1,32'h11,       1,2,32'h22,   0,0, 0,0, 1,0,0, 1,1,32'h11,16'h0000);
    vecs[6]  = mk(1,1,32'h11,       1,2,32'h22,   0,0, 0,0, 0,1,0, 1,2,32'h22,16'h0000);
    vecs[7]  = mk(0,0,0,            0,0,0,        1,5, 5,0, 0,0,0, 0,2,32'h22,16'h0020);
    vecs[8]  = mk(0,0,0,            1,5,32'h55,   0,0, 5,0, 0,1,1, 1,5,32'h55,16'h0000);
    vecs[9]  = mk(0,0,0,            0,0,0,        0,0, 5,0, 0,0,0, 0,5,32'h55,16'h0000);
    vecs[10] = mk(1,7,32'h77,       0,0,0,        1,7, 0,0, 1,0,0, 1,7,32'h77,16'h0080);
    vecs[11] = mk(0,0,0,            0,0,0,        0,0, 0,7, 0,0,1, 0,7,32'h77,16'h0080);
    vecs[12] = mk(0,0,0,            1,7,32'h70,   1,0, 0,0, 0,1,0, 1,7,32'h70,16'h0001);
    vecs[13] = mk(0,0,0,            0,0,0,        1,0, 0,0, 0,0,1, 0,7,32'h70,16'h0001);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wb.alu_req = vecs[i].ar; wb.alu_dest = vecs[i].ad; wb.alu_data = vecs[i].adata;
      wb.mem_req = vecs[i].mr; wb.mem_dest = vecs[i].md; wb.mem_data = vecs[i].mdata;
      issue_valid = vecs[i].iv; issue_dest = vecs[i].id;
      chk_src1 = vecs[i].s1; chk_src2 = vecs[i].s2;
      #1;
      check($sformatf("vec%0d_alu_gnt", i), 32'(wb.alu_gnt), 32'(vecs[i].e_agnt));
      check($sformatf("vec%0d_mem_gnt", i), 32'(wb.mem_gnt), 32'(vecs[i].e_mgnt));
      check($sformatf("vec%0d_hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
      @(posedge clk); #1;
      check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_rf_dest", i), 32'(rf_dest), 32'(vecs[i].e_dest));
      check($sformatf("vec%0d_rf_data", i), rf_data, vecs[i].e_data);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      $display("vec %0d: gnt a=%0b m=%0b rf_we=%0b rf_dest=%0d rf_data=0x%08h busy=0x%04h",
               i, vecs[i].e_agnt, vecs[i].e_mgnt, rf_we, rf_dest, rf_data, busy);
    end

    // ---------------- reset mid-operation ----------------
    // Make ALU the last winner so the post-reset conflict shows the reset
    // of the round-robin state.
    @(negedge clk);
    set_idle();
    wb.alu_req = 1'b1; wb.alu_dest = 4'd4; wb.alu_data = 32'hAA;
    @(posedge clk);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      set_idle();
      issue_valid = 1'b1; issue_dest = 4'(r);
      @(posedge clk);
    end
    #1;
    check("fill_busy", 32'(busy), 32'h0000FFFF);
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    wb.alu_req = 1'b1; wb.alu_dest = 4'd1; wb.alu_data = 32'hA1;
    wb.mem_req = 1'b1; wb.mem_dest = 4'd2; wb.mem_data = 32'hB2;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_rf_dest", 32'(rf_dest), 32'd0);
    check("midrst_rf_data", rf_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_alu_gnt", 32'(wb.alu_gnt), 32'd1);
    check("postrst_mem_gnt", 32'(wb.mem_gnt), 32'd0);
    @(posedge clk); #1;
    check("postrst_rf_dest", 32'(rf_dest), 32'd1);
    $display("reset test: first post-reset conflict wrote rf_dest=%0d rf_data=0x%08h", rf_dest, rf_data);

    // ---------------- randomized run vs model ----------------
    do_reset();
    a_pend = 0; m_pend = 0;
    a_d = '0; m_d = '0; a_data = '0; m_data = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!a_pend && $urandom_range(0, 99) < 60) begin
        a_pend = 1; a_d = 4'($urandom_range(0, 15)); a_data = $urandom;
      end
      if (!m_pend && $urandom_range(0, 99) < 60) begin
        m_pend = 1; m_d = 4'($urandom_range(0, 15)); m_data = $urandom;
      end
      iv_r = ($urandom_range(0, 99) < 30);
      id_r = 4'($urandom_range(0, 15));
      s1_r = 4'($urandom_range(0, 15));
      s2_r = 4'($urandom_range(0, 15));
      wb.alu_req = a_pend; wb.alu_dest = a_d; wb.alu_data = a_data;
      wb.mem_req = m_pend; wb.mem_dest = m_d; wb.mem_data = m_data;
      issue_valid = iv_r; issue_dest = id_r; chk_src1 = s1_r; chk_src2 = s2_r;

      // Model: lone requester wins; on conflict the non-last winner wins.
      exp_a = 0; exp_m = 0;
      if (a_pend && m_pend) begin
        if (last_m == WB_MEM) exp_a = 1; else exp_m = 1;
      end else if (a_pend) exp_a = 1;
      else if (m_pend) exp_m = 1;
      exp_h = busy_m[s1_r] | busy_m[s2_r];

      #1;
      check("rand_alu_gnt", 32'(wb.alu_gnt), 32'(exp_a));
      check("rand_mem_gnt", 32'(wb.mem_gnt), 32'(exp_m));
      check("rand_hazard", 32'(hazard), 32'(exp_h));

      @(posedge clk); #1;
      we_m = exp_a | exp_m;
      if (exp_a) begin
        busy_m[a_d] = 1'b0; dest_m = a_d; data_m = a_data; last_m = WB_ALU; a_pend = 0;
      end else if (exp_m) begin
        busy_m[m_d] = 1'b0; dest_m = m_d; data_m = m_data; last_m = WB_MEM; m_pend = 0;
      end
      if (iv_r) busy_m[id_r] = 1'b1;

      check("rand_rf_we", 32'(rf_we), 32'(we_m));
      check("rand_rf_dest", 32'(rf_dest), 32'(dest_m));
      check("rand_rf_data", rf_data, data_m);
      check("rand_busy", 32'(busy), 32'(pack_busy()));
      $display("rand %0d: gnt a=%0b m=%0b issue=%0b/%0d rf_we=%0b rf_dest=%0d busy=0x%04h",
               c, exp_a, exp_m, iv_r, id_r, rf_we, rf_dest, busy);
    end

`ifdef REGFILE_WB_STATS_EN
    // ---------------- conflict counter ----------------
    do_reset();
    wb.alu_req = 1'b1; wb.alu_dest = 4'd1; wb.alu_data = 32'h1;
    wb.mem_req = 1'b1; wb.mem_dest = 4'd2; wb.mem_data = 32'h2;
    repeat (3) @(posedge clk);
    #1;
    check("stats_cnt3", 32'(conflict_cnt), 32'd3);
    $display("stats: conflict_cnt=%0d after 3 conflict cycles", conflict_cnt);
    @(negedge clk);
    set_idle();
    force dut.conflict_cnt_reg = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.conflict_cnt_reg;
    wb.alu_req = 1'b1; wb.mem_req = 1'b1;
    @(posedge clk); #1;
    check("stats_saturate", 32'(conflict_cnt), 32'h0000FFFF);
    $display("stats: conflict_cnt=0x%04h after saturating conflict", conflict_cnt);
    @(negedge clk);
    set_idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
